// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Turns one-cycle step requests from the tracking regulator into
//   timing-correct STEP/DIR/ENABLE signals for an external stepper driver.
//   Guarantees DIR setup before STEP rises, a minimum STEP high width and a
//   minimum STEP low gap. One request arriving while busy is buffered; a
//   further one is dropped and flagged in the sticky overrun bit. A signed
//   position counter follows every issued pulse.
//
// Optional build macro: STEP_SOFT_LIMIT_EN
//   Adds POS_MIN/POS_MAX parameters and the limit_hit output. A request that
//   would carry pos outside [POS_MIN, POS_MAX] is discarded at its launch
//   decision and limit_hit pulses for one cycle.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   sm_en      in   motor enable from the regulator
//   step_req   in   one-cycle step request
//   dir_req    in   direction of step_req (1 = forward)
//   clr_ovr    in   synchronous clear of overrun
//   step_out   out  STEP pin
//   dir_out    out  DIR pin
//   en_out     out  ENABLE pin (sm_en delayed one cycle)
//   busy       out  pulse sequence in progress or request pending
//   overrun    out  sticky, a request was dropped
//   pos        out  signed step position (wraps)
//   limit_hit  out  (STEP_SOFT_LIMIT_EN only) request rejected by soft limit
module step_pulse_gen #(
  parameter int unsigned DIR_SETUP = 10,
  parameter int unsigned PULSE_W   = 50,
  parameter int unsigned PULSE_GAP = 50,
  parameter int unsigned POS_W     = 16
`ifdef STEP_SOFT_LIMIT_EN
  ,
  parameter int          POS_MIN   = -1000,
  parameter int          POS_MAX   = 1000
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sm_en,
  input  logic                    step_req,
  input  logic                    dir_req,
  input  logic                    clr_ovr,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    en_out,
  output logic                    busy,
  output logic                    overrun,
  output logic signed [POS_W-1:0] pos
`ifdef STEP_SOFT_LIMIT_EN
  ,
  output logic                    limit_hit
`endif
);

  localparam int unsigned MAXC_A = (DIR_SETUP > PULSE_W) ? DIR_SETUP : PULSE_W;
  localparam int unsigned MAXC   = (MAXC_A > PULSE_GAP) ? MAXC_A : PULSE_GAP;
  // Counters load N-1 and count down to zero, so N cycles are spent per state.
  localparam int unsigned CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(PULSE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dir_l_q, dir_l_d;
  logic                    dir_q, dir_d;
  logic                    step_q, step_d;
  logic                    en_q;
  logic                    pend_q, pend_d;
  logic                    pend_dir_q, pend_dir_d;
  logic                    ovr_q, ovr_d;
  logic signed [POS_W-1:0] pos_q, pos_d;

  logic accept, decide, src_pend, src_req, start, start_dir, consume;
  logic blocked, enter_high, high_dir, ovr_set;

  // Request arbitration: the pending slot has priority over a fresh request.
  // A launch decision happens in IDLE or in the last LOW cycle.
  always_comb begin
    accept    = sm_en & step_req;
    decide    = (state_q == S_IDLE) || ((state_q == S_LOW) && (cnt_q == '0));
    src_pend  = pend_q & sm_en;
    src_req   = (state_q == S_IDLE) & ~src_pend & accept;
    start     = decide & (src_pend | src_req);
    start_dir = src_pend ? pend_dir_q : dir_req;
    consume   = decide & src_pend;
  end

`ifdef STEP_SOFT_LIMIT_EN
  localparam logic signed [POS_W:0] MIN_L = (POS_W+1)'(POS_MIN);
  localparam logic signed [POS_W:0] MAX_L = (POS_W+1)'(POS_MAX);
  logic signed [POS_W:0] tgt;
  logic                  lim_d, lim_q;

  // One extra bit so the range test sees the unwrapped target.
  always_comb begin
    tgt     = {pos_q[POS_W-1], pos_q} + (start_dir ? (POS_W+1)'(1) : '1);
    blocked = (tgt < MIN_L) || (tgt > MAX_L);
  end
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    dir_l_d    = dir_l_q;
    enter_high = 1'b0;
    high_dir   = dir_l_q;
`ifdef STEP_SOFT_LIMIT_EN
    lim_d      = 1'b0;
`endif

    case (state_q)
      S_SETUP: begin
        if (cnt_q == '0) enter_high = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    // LOW's last cycle shares IDLE's decision so back-to-back pulses add no idle cycle.
    if (decide) begin
      state_d = S_IDLE;
      if (start) begin
        if (blocked) begin
`ifdef STEP_SOFT_LIMIT_EN
          lim_d = 1'b1;
`endif
        end else begin
          dir_l_d = start_dir;
          if (start_dir != dir_q) begin
            dir_d   = start_dir;
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            enter_high = 1'b1;
            high_dir   = start_dir;
          end
        end
      end
    end

    if (enter_high) begin
      state_d = S_HIGH;
      cnt_d   = HIGH_LD;
    end

    pos_d  = enter_high ? (high_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1)) : pos_q;
    step_d = (state_d == S_HIGH);

    // A slot freed by this cycle's launch can take this cycle's request.
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    ovr_set    = 1'b0;
    if (!sm_en || consume) pend_d = 1'b0;
    if (accept && !src_req) begin
      if (!pend_q || consume) begin
        pend_d     = 1'b1;
        pend_dir_d = dir_req;
      end else begin
        ovr_set = 1'b1;
      end
    end
    ovr_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dir_l_q    <= 1'b0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      en_q       <= 1'b0;
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
      ovr_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_l_q    <= dir_l_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      en_q       <= sm_en;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      ovr_q      <= ovr_d;
      pos_q      <= pos_d;
    end
  end

`ifdef STEP_SOFT_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lim_q <= 1'b0;
    else     lim_q <= lim_d;
  end
  assign limit_hit = lim_q;
`endif

  assign step_out = step_q;
  assign dir_out  = dir_q;
  assign en_out   = en_q;
  assign busy     = (state_q != S_IDLE) | pend_q;
  assign overrun  = ovr_q;
  assign pos      = pos_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen: directed vector table, hand-written corner
// sequences (enable drop, reset mid-pulse, soft limit when built with
// STEP_SOFT_LIMIT_EN) and randomized traffic against a timeline model.
module tb_step_pulse_gen;

  localparam int DS = 10;
  localparam int PW = 50;
  localparam int PG = 50;
`ifdef STEP_SOFT_LIMIT_EN
  localparam int LIM_MIN = -3;
  localparam int LIM_MAX = 2;
`endif

  logic clk = 1'b0;
  logic rst, sm_en, step_req, dir_req, clr_ovr;
  logic step_out, dir_out, en_out, busy, overrun, limit_hit;
  logic signed [15:0] pos;

  always #5 clk = ~clk;

`ifdef STEP_SOFT_LIMIT_EN
  step_pulse_gen #(.DIR_SETUP(DS), .PULSE_W(PW), .PULSE_GAP(PG), .POS_W(16),
                   .POS_MIN(LIM_MIN), .POS_MAX(LIM_MAX)) dut (
    .clk(clk), .rst(rst), .sm_en(sm_en), .step_req(step_req), .dir_req(dir_req),
    .clr_ovr(clr_ovr), .step_out(step_out), .dir_out(dir_out), .en_out(en_out),
    .busy(busy), .overrun(overrun), .pos(pos), .limit_hit(limit_hit));
`else
  step_pulse_gen #(.DIR_SETUP(DS), .PULSE_W(PW), .PULSE_GAP(PG), .POS_W(16)) dut (
    .clk(clk), .rst(rst), .sm_en(sm_en), .step_req(step_req), .dir_req(dir_req),
    .clr_ovr(clr_ovr), .step_out(step_out), .dir_out(dir_out), .en_out(en_out),
    .busy(busy), .overrun(overrun), .pos(pos));
  assign limit_hit = 1'b0;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic [3:0] def_in = 4'b1000;   // {sm_en, step_req, dir_req, clr_ovr}

  // ---------------- reference model: absolute-time schedule ----------------
  int  m_n, m_rise, m_fall, m_done;
  bit  m_act, m_dl, m_pend, m_pdir, m_ovr, m_dout, m_en, m_lim;
  logic signed [15:0] m_pos;

  function automatic void m_reset();
    m_n = 0; m_rise = 0; m_fall = 0; m_done = 0;
    m_act = 0; m_dl = 0; m_pend = 0; m_pdir = 0; m_ovr = 0;
    m_dout = 0; m_en = 0; m_lim = 0; m_pos = '0;
  endfunction

  // Schedule a pulse decided at cycle m_n: dir edge next cycle if needed,
  // rise after setup, then PW high cycles and PG low cycles.
  function automatic void m_launch(bit d);
`ifdef STEP_SOFT_LIMIT_EN
    int p;
    p = int'(m_pos) + (d ? 1 : -1);
    if (p < LIM_MIN || p > LIM_MAX) begin
      m_lim = 1;
      return;
    end
`endif
    m_act = 1;
    m_dl  = d;
    if (d != m_dout) begin
      m_dout = d;
      m_rise = m_n + 1 + DS;
    end else begin
      m_rise = m_n + 1;
    end
    m_fall = m_rise + PW;
    m_done = m_fall + PG - 1;
  endfunction

  function automatic void m_step(bit en, bit req, bit d, bit clr);
    bit dec, was_act, pend_ok, acc, used, set_ovr;
    was_act = m_act;
    dec     = !m_act || (m_n == m_done);
    pend_ok = m_pend && en;
    acc     = en && req;
    m_pend  = pend_ok;
    used    = 0;
    set_ovr = 0;
    m_lim   = 0;
    if (dec) begin
      m_act = 0;
      if (pend_ok) begin
        m_pend = 0;
        m_launch(m_pdir);
      end else if (acc && !was_act) begin
        used = 1;
        m_launch(d);
      end
    end
    if (acc && !used) begin
      if (!m_pend) begin m_pend = 1; m_pdir = d; end
      else set_ovr = 1;
    end
    m_ovr = set_ovr ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_en  = en;
    m_n++;
    if (m_act && m_n == m_rise) m_pos = m_dl ? m_pos + 16'sd1 : m_pos - 16'sd1;
  endfunction

  function automatic logic [21:0] m_out();
    bit st;
    st = m_act && (m_n >= m_rise) && (m_n < m_fall);
    return {m_lim, st, m_dout, (m_act || m_pend), m_ovr, m_en, m_pos};
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [21:0] act_out();
    return {limit_hit, step_out, dir_out, busy, overrun, en_out, pos};
  endfunction

  task automatic cmp(input string name, input logic [21:0] exp_v);
    logic [21:0] got;
    got = act_out();
    n_vec++;
    if (got !== exp_v) begin
      n_miss++;
      $display("FAIL %s cyc=%0d: got lim,step,dir,busy,ovr,en=%b pos=%0d, expected %b pos=%0d",
               name, cyc, got[21:16], $signed(got[15:0]), exp_v[21:16], $signed(exp_v[15:0]));
    end
  endtask

  task automatic chk(input string name, input logic [4:0] e, input logic signed [15:0] p,
                     input logic l = 1'b0);
    cmp(name, {l, e, p});
  endtask

  task automatic drive(input logic [3:0] v);
    {sm_en, step_req, dir_req, clr_ovr} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_in(input logic [3:0] v);
    drive(v);
    tick();
  endtask

  task automatic goto(input int t);
    while (cyc < t) step_in(def_in);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    cyc    = 0;
    def_in = 4'b1000;
    m_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int                 scen;
    int                 cyc;
    logic [3:0]         in;    // {sm_en, step_req, dir_req, clr_ovr} for this cycle
    bit                 chk;
    logic [4:0]         ex;    // {step, dir, busy, ovr, en} seen in this cycle
    logic signed [15:0] pos;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int s, input int c, input logic [3:0] i, input bit k,
                     input logic [4:0] e, input int p);
    vec_t v;
    v.scen = s; v.cyc = c; v.in = i; v.chk = k; v.ex = e; v.pos = 16'(p);
    tbl.push_back(v);
  endtask

  initial begin
    bit en_r, req_r, dir_r, clr_r;
    int last_scen;
    rst = 1'b1;
    drive(4'b0000);

    // same direction: no setup, pulse 1..50, gap 51..100
    add(0,   0, 4'b1100, 1, 5'b00000,  0);
    add(0,   1, 4'b1000, 1, 5'b10101, -1);
    add(0,  50, 4'b1000, 1, 5'b10101, -1);
    add(0,  51, 4'b1000, 1, 5'b00101, -1);
    add(0, 100, 4'b1000, 1, 5'b00101, -1);
    add(0, 101, 4'b1000, 1, 5'b00001, -1);
    // direction change: DIR at 1, STEP 11..60
    add(1,   0, 4'b1110, 1, 5'b00000,  0);
    add(1,   1, 4'b1000, 1, 5'b01101,  0);
    add(1,  10, 4'b1000, 1, 5'b01101,  0);
    add(1,  11, 4'b1000, 1, 5'b11101,  1);
    add(1,  60, 4'b1000, 1, 5'b11101,  1);
    add(1,  61, 4'b1000, 1, 5'b01101,  1);
    add(1, 111, 4'b1000, 1, 5'b01001,  1);
    // requests at 0,5,6: one buffered, one dropped; clear at 300
    add(2,   0, 4'b1100, 0, 5'b00000,  0);
    add(2,   5, 4'b1100, 0, 5'b00000,  0);
    add(2,   6, 4'b1100, 1, 5'b10101, -1);
    add(2,   7, 4'b1000, 1, 5'b10111, -1);
    add(2, 100, 4'b1000, 1, 5'b00111, -1);
    add(2, 101, 4'b1000, 1, 5'b10111, -2);
    add(2, 201, 4'b1000, 1, 5'b00011, -2);
    add(2, 300, 4'b1001, 1, 5'b00011, -2);
    add(2, 301, 4'b1000, 1, 5'b00001, -2);

    last_scen = -1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].scen != last_scen) begin
        do_reset();
        last_scen = tbl[i].scen;
      end
      goto(tbl[i].cyc);
      if (tbl[i].chk) chk($sformatf("tbl_s%0d_c%0d", tbl[i].scen, tbl[i].cyc), tbl[i].ex, tbl[i].pos);
      step_in(tbl[i].in);
    end

    // sm_en drops at 20 during HIGH with one pending
    do_reset();
    step_in(4'b1100);
    goto(5);
    step_in(4'b1100);
    goto(20);
    def_in = 4'b0000;
    goto(21);
    chk("en_drop_c21", 5'b10100, -1);
    goto(30);
    step_in(4'b0100);
    goto(50);
    chk("en_drop_c50", 5'b10100, -1);
    goto(51);
    chk("en_drop_c51", 5'b00100, -1);
    goto(100);
    chk("en_drop_c100", 5'b00100, -1);
    goto(101);
    chk("en_drop_c101", 5'b00000, -1);
    goto(150);
    chk("en_drop_c150", 5'b00000, -1);

    // reset mid-pulse is seen before the next clock edge
    do_reset();
    step_in(4'b1100);
    goto(30);
    chk("rst_pre", 5'b10101, -1);
    rst = 1'b1;
    #2;
    chk("rst_async", 5'b00000, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    def_in = 4'b1000;
    step_in(4'b1100);
    chk("rst_after_c1", 5'b10101, -1);
    goto(51);
    chk("rst_after_c51", 5'b00101, -1);
    goto(101);
    chk("rst_after_c101", 5'b00001, -1);

`ifdef STEP_SOFT_LIMIT_EN
    // forward requests every 200 cycles with POS_MAX = 2
    do_reset();
    step_in(4'b1110);
    goto(11);
    chk("lim_c11", 5'b11101, 1);
    goto(200);
    step_in(4'b1110);
    chk("lim_c201", 5'b11101, 2);
    goto(400);
    step_in(4'b1110);
    chk("lim_c401", 5'b01001, 2, 1'b1);
    step_in(4'b1000);
    chk("lim_c402", 5'b01001, 2);
    goto(600);
    step_in(4'b1110);
    chk("lim_c601", 5'b01001, 2, 1'b1);
    goto(700);
    chk("lim_c700", 5'b01001, 2);
`endif

    // randomized traffic against the timeline model
    do_reset();
    en_r = 1;
    for (int k = 0; k < 6000; k++) begin
      cmp("rand", m_out());
      if ($urandom_range(0, 299) == 0) en_r = !en_r;
      req_r = ($urandom_range(0, 29) == 0);
      dir_r = 1'($urandom_range(0, 1));
      clr_r = ($urandom_range(0, 99) == 0);
      drive({en_r, req_r, dir_r, clr_r});
      m_step(en_r, req_r, dir_r, clr_r);
      tick();
    end
    cmp("rand_end", m_out());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Downstream of the tracking regulator: consumes its one-cycle step requests and direction, and produces timing-correct STEP/DIR/ENABLE signals for the external stepper driver.
- Enforces DIR setup time, minimum STEP high width and minimum STEP low gap.
- Buffers one request taken while busy, flags overruns, and keeps a signed position count.

Parameters:
- DIR_SETUP, 10, clk cycles between a DIR change and the STEP rising edge (200 ns at 50 MHz).
- PULSE_W, 50, clk cycles STEP is held high.
- PULSE_GAP, 50, clk cycles STEP is held low before the next pulse may start.
- POS_W, 16, width of the signed position counter.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- sm_en  in  1  motor enable from the regulator (drv_SM).
- step_req  in  1  one-cycle step request (drv_step).
- dir_req  in  1  direction for step_req: 1 = forward, 0 = reverse (drv_dir).
- clr_ovr  in  1  synchronous clear of overrun.
- step_out  out  1  STEP pin to driver.
- dir_out  out  1  DIR pin to driver.
- en_out  out  1  ENABLE pin, sm_en registered.
- busy  out  1  high when the FSM is not IDLE or a request is pending.
- overrun  out  1  sticky; a request was dropped.
- pos  out  POS_W  signed step position.

Behaviour:
- Reset, asynchronous: all outputs 0, pos = 0, pending slot empty, FSM in IDLE. Reset mid-pulse drops step_out immediately.
- en_out is sm_en delayed by 1 cycle.
- step_req is accepted only when sm_en = 1; otherwise it is ignored and does not set overrun.
- FSM states: IDLE, SETUP, HIGH, LOW.
- IDLE, on request (pending slot first, else step_req):
  - latch the request direction as dir_l;
  - if dir_l != dir_out: set dir_out = dir_l and go to SETUP;
  - else go straight to HIGH.
- SETUP: hold for DIR_SETUP cycles, then go to HIGH.
- HIGH:
  - on entry, step_out = 1 and pos increments (dir_l = 1) or decrements (dir_l = 0), with two's-complement wrap;
  - hold for PULSE_W cycles, then go to LOW.
- LOW:
  - step_out = 0 for PULSE_GAP cycles;
  - at the end, if the pending slot is full, start it directly (same decision as IDLE, no IDLE cycle); else go to IDLE.
- Latency: step_req at cycle N with unchanged direction gives step_out = 1 at N+1. With a direction change: dir_out toggles at N+1, step_out rises at N+1+DIR_SETUP.
- step_req while not IDLE:
  - pending slot empty: store the request and its dir in the slot;
  - slot full: drop the request and set overrun = 1.
  - If the slot is being consumed in the same cycle (LOW→next), the new request is stored, not dropped.
- overrun clears on clr_ovr = 1 or rst. If step_req overflows in the same cycle as clr_ovr, set wins.
- sm_en falls mid-operation:
  - the current pulse runs to completion through LOW; STEP is never truncated;
  - the pending slot is discarded;
  - new requests are ignored.
- Counters count exactly the parameter value. All parameters must be >= 1.

Optional Feature:
- Macro: STEP_SOFT_LIMIT_EN.
- When defined, adds:
  - parameters POS_MIN (default -1000) and POS_MAX (default 1000);
  - output limit_hit.
- A request that would move pos beyond [POS_MIN, POS_MAX] is discarded when it reaches IDLE decision:
  - no DIR change, no pulse;
  - limit_hit = 1 for 1 cycle;
  - overrun is not affected.
- When undefined: no limit logic, no limit_hit port, pos wraps freely.

Test Plan:
- After reset, sm_en = 1, step_req with dir_req = 0 at cycle 0 -> dir_out stays 0; step_out = 1 cycles 1..50, 0 cycles 51..100; pos = -1 from cycle 1; busy = 0 at cycle 101.
- After reset, step_req with dir_req = 1 at cycle 0 -> dir_out = 1 at cycle 1; step_out = 1 cycles 11..60; pos = +1.
- Three same-direction step_req pulses at cycles 0, 5, 6 -> two pulses issued (second rising at cycle 101, no gap cycle added); overrun = 1 from cycle 7; clr_ovr at cycle 300 -> overrun = 0 at 301.
- sm_en drops at cycle 20 during HIGH with one pending -> step_out stays high to cycle 50, low through 100; pending discarded; pos = ±1 only; en_out = 0 at cycle 21.
- rst asserted at cycle 30 mid-pulse -> step_out, pos, busy = 0 asynchronously; after release a new request behaves as in test 1.
- With STEP_SOFT_LIMIT_EN, POS_MAX = 2: four forward requests spaced 200 cycles apart -> two pulses issued, pos = 2; limit_hit pulses once for each of the 3rd and 4th requests.
